// File: rtl/pc_gen.sv
// pc_gen: registered program-counter generator with interrupt entry and a
// nested return-address (EPC) stack.
//
// Every cycle the next PC is chosen from three sources, highest first:
//   1. eret      - pop the EPC stack and resume there; an eret with an
//                  empty stack falls back to npc and sets err_unf.
//   2. interrupt - push int_epc, jump to EXC_VECTOR. A full stack blocks
//                  the interrupt, which stays pending until there is room.
//   3. npc       - sequential or branch address from the core.
//
// Requests that arrive while stalled, or that lose to an eret, are latched
// and serviced on a later unstalled cycle. Stack storage is not reset.
// depth is the only stack pointer, and reset clears it.
module pc_gen #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_4180,
  parameter int               EPC_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [WIDTH-1:0] npc,
  input  logic             int_req,
  input  logic [WIDTH-1:0] int_epc,
  input  logic             int_back,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] epc_top,
  output logic [4:0]       depth,
  output logic             int_pending,
  output logic             int_blocked,
  output logic             err_unf
);

  // Index width for the stack array. depth itself needs a fifth bit so
  // that it can hold EPC_DEPTH (up to 16) when the stack is full.
  localparam int         PTR_W     = (EPC_DEPTH > 1) ? $clog2(EPC_DEPTH) : 1;
  localparam logic [4:0] DEPTH_MAX = 5'(EPC_DEPTH);

  // EPC storage. It has no reset because entries above depth are never read.
  logic [WIDTH-1:0] r_stack [EPC_DEPTH];

  logic [WIDTH-1:0] r_pc;
  logic [4:0]       r_depth;
  logic             r_int_pending;
  logic             r_ret_pending;
  logic             r_err_unf;

  logic             w_eret;
  logic             w_irq;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic [4:0]       w_top_depth;
  logic [PTR_W-1:0] w_push_idx;
  logic [PTR_W-1:0] w_top_idx;

  // A request counts whether it was latched earlier or is arriving on this
  // cycle. This lets a single-cycle pulse act immediately when the core is
  // not stalled.
  assign w_eret      = r_ret_pending | int_back;
  assign w_irq       = r_int_pending | int_req;
  assign w_empty     = (r_depth == 5'd0);
  assign w_full      = (r_depth == DEPTH_MAX);

  // A push happens only when no eret is active. Push and pop therefore
  // never happen on the same edge.
  assign w_push      = ~stall & ~w_eret & w_irq & ~w_full;

  // Push writes the slot at depth. The top entry is the slot at depth-1.
  assign w_top_depth = r_depth - 5'd1;
  assign w_push_idx  = r_depth[PTR_W-1:0];
  assign w_top_idx   = w_top_depth[PTR_W-1:0];

  // Write the return address of a taken interrupt into the next free slot.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_push_idx] <= int_epc;
    end
  end

  // Select the PC source and track depth and the pending and sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_VECTOR;
      r_depth       <= 5'd0;
      r_int_pending <= 1'b0;
      r_ret_pending <= 1'b0;
      r_err_unf     <= 1'b0;
    end else if (stall) begin
      // PC and stack are frozen, but requests are still latched so that a
      // pulse during the stall is not lost.
      r_int_pending <= w_irq;
      r_ret_pending <= w_eret;
    end else begin
      r_ret_pending <= 1'b0;
      if (w_eret) begin
        // The eret wins. A concurrent interrupt stays pending for a later cycle.
        r_int_pending <= w_irq;
        if (!w_empty) begin
          r_pc    <= r_stack[w_top_idx];
          r_depth <= r_depth - 5'd1;
        end else begin
          r_pc      <= npc;
          r_err_unf <= 1'b1;
        end
      end else if (w_irq && !w_full) begin
        r_pc          <= EXC_VECTOR;
        r_depth       <= r_depth + 5'd1;
        r_int_pending <= 1'b0;
      end else begin
        // This is normal flow, or an interrupt blocked by a full stack,
        // which keeps waiting.
        r_pc          <= npc;
        r_int_pending <= w_irq;
      end
    end
  end

  assign pc          = r_pc;
  assign depth       = r_depth;
  assign epc_top     = w_empty ? '0 : r_stack[w_top_idx];
  assign int_pending = r_int_pending;
  assign int_blocked = r_int_pending & w_full;
  assign err_unf     = r_err_unf;

endmodule
